apb_master: RTL and testbench

- APB initiator (bridge) that converts a simple single-request CPU-side interface into APB SETUP/ACCESS transfers.
- Decodes the address onto one of NUM_SLV peripheral slots (e.g. FIFO, GPIO, UART peripherals) and drives that slot's PSEL line.
- Muxes the selected slave's PRDATA/PREADY back to the requester.
- Reports a decode miss and a PREADY timeout as bus errors, so software never hangs on a dead slot.

---
 rtl/apb_master.sv | 142 ++++++++++++++
 tb/tb_apb_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB initiator: turns a single-request CPU-side handshake into APB SETUP/ACCESS
// transfers, decodes the target slot and reports decode misses and PREADY timeouts.
module apb_master #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          SLOT_LSB  = 12,
    parameter int          TIMEOUT   = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    transfer,
    input  logic                    write,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic                    err,
    output logic [SLOT_LSB-1:0]     PADDR,
    output logic [31:0]             PWDATA,
    output logic                    PWRITE,
    output logic [NUM_SLV-1:0]      PSEL,
    output logic                    PENABLE,
    input  logic [32*NUM_SLV-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY
);

    localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TAG_LSB = SLOT_LSB + IDX_W;
    localparam int CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [31:0]            rdata_q;
    logic                   ready_q;
    logic                   err_q;
    logic [SLOT_LSB-1:0]    paddr_q;
    logic [31:0]            pwdata_q;
    logic                   pwrite_q;
    logic [NUM_SLV-1:0]     psel_q;
    logic                   penable_q;

    logic [IDX_W-1:0]       req_idx;
    logic                   req_hit;
    logic                   slv_ready;
    logic                   launch;

    // A slot index beyond NUM_SLV (non power-of-two slot counts) is treated as a miss.
    assign req_idx   = addr[SLOT_LSB +: IDX_W];
    assign req_hit   = (addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) && (int'(req_idx) < NUM_SLV);
    assign slv_ready = PREADY[idx_q];

    // New requests are only taken in IDLE or on the cycle that completes an ACCESS.
    assign launch = transfer && req_hit &&
                    ((state_q == S_IDLE) || ((state_q == S_ACCESS) && slv_ready));

    // NOTE: state and outputs use non-blocking assignments so every branch sees
    // the pre-edge values; the reset branch clears every register, there is no memory.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (transfer && !req_hit) begin
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end

                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (slv_ready) begin
                        ready_q   <= 1'b1;
                        rdata_q   <= pwrite_q ? 32'h0 : PRDATA[32*idx_q +: 32];
                        penable_q <= 1'b0;
                        psel_q    <= '0;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        penable_q <= 1'b0;
                        psel_q    <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase

            // Overrides the IDLE return above for back-to-back transfers.
            if (launch) begin
                idx_q     <= req_idx;
                cnt_q     <= '0;
                paddr_q   <= addr[SLOT_LSB-1:0];
                pwdata_q  <= wdata;
                pwrite_q  <= write;
                psel_q    <= NUM_SLV'(1) << req_idx;
                penable_q <= 1'b0;
                state_q   <= S_SETUP;
            end
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait write, waited read, decode miss,
// back-to-back writes, reset mid-access and PREADY timeout.
module tb_apb_master;

    logic         PCLK;
    logic         PRESET;
    logic         transfer;
    logic         write;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [11:0]  PADDR;
    logic [31:0]  PWDATA;
    logic         PWRITE;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int n_assert = 0;
    int n_fail   = 0;

    apb_master #(
        .NUM_SLV   (4),
        .BASE_ADDR (32'h1000_0000),
        .SLOT_LSB  (12),
        .TIMEOUT   (16)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, " PSEL"},    32'(PSEL),    32'h0);
        check({tag, " PENABLE"}, 32'(PENABLE), 32'h0);
        check({tag, " ready"},   32'(ready),   32'h0);
    endtask

    initial begin
        PRESET   = 1'b1;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        PRDATA   = '0;
        PREADY   = 4'b0000;
        repeat (3) step();

        // Reset state
        check("rst PSEL",    32'(PSEL),    32'h0);
        check("rst PENABLE", 32'(PENABLE), 32'h0);
        check("rst PWRITE",  32'(PWRITE),  32'h0);
        check("rst PADDR",   32'(PADDR),   32'h0);
        check("rst PWDATA",  PWDATA,       32'h0);
        check("rst rdata",   rdata,        32'h0);
        check("rst ready",   32'(ready),   32'h0);
        check("rst err",     32'(err),     32'h0);
        PRESET = 1'b0;
        step();
        idle_outputs("idle");

        // 1. zero-wait write to slave1
        PREADY   = 4'b0010;
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_1004; wdata = 32'h0000_00AA;
        step();
        transfer = 1'b0;
        check("t1 setup PSEL",    32'(PSEL),    32'h2);
        check("t1 setup PENABLE", 32'(PENABLE), 32'h0);
        check("t1 setup PADDR",   32'(PADDR),   32'h004);
        check("t1 setup PWDATA",  PWDATA,       32'hAA);
        check("t1 setup PWRITE",  32'(PWRITE),  32'h1);
        check("t1 setup ready",   32'(ready),   32'h0);
        step();
        check("t1 access PSEL",    32'(PSEL),    32'h2);
        check("t1 access PENABLE", 32'(PENABLE), 32'h1);
        check("t1 access ready",   32'(ready),   32'h0);
        step();
        check("t1 done ready",   32'(ready),   32'h1);
        check("t1 done err",     32'(err),     32'h0);
        check("t1 done rdata",   rdata,        32'h0);
        check("t1 done PSEL",    32'(PSEL),    32'h0);
        check("t1 done PENABLE", 32'(PENABLE), 32'h0);
        step();
        check("t1 pulse ready", 32'(ready), 32'h0);

        // 2. read from slave1 with two wait states; slave2 PREADY must be ignored
        PREADY         = 4'b0100;
        PRDATA[63:32]  = 32'h0000_00BB;
        PRDATA[95:64]  = 32'hDEAD_BEEF;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1008; wdata = 32'h0;
        step();
        transfer = 1'b0;
        check("t2 setup PSEL",   32'(PSEL),   32'h2);
        check("t2 setup PADDR",  32'(PADDR),  32'h008);
        check("t2 setup PWRITE", 32'(PWRITE), 32'h0);
        step();
        check("t2 access PENABLE", 32'(PENABLE), 32'h1);
        step();
        check("t2 wait1 ready",   32'(ready),   32'h0);
        check("t2 wait1 PENABLE", 32'(PENABLE), 32'h1);
        step();
        check("t2 wait2 ready", 32'(ready), 32'h0);
        check("t2 wait2 PSEL",  32'(PSEL),  32'h2);
        PREADY = 4'b0010;
        step();
        check("t2 done ready", 32'(ready), 32'h1);
        check("t2 done err",   32'(err),   32'h0);
        check("t2 done rdata", rdata,      32'hBB);
        check("t2 done PSEL",  32'(PSEL),  32'h0);
        PREADY = 4'b0000;

        // 4. decode miss: no APB activity, error on next cycle with rdata cleared
        transfer = 1'b1; write = 1'b0; addr = 32'h2000_0000;
        step();
        transfer = 1'b0;
        check("t4 miss PSEL",    32'(PSEL),    32'h0);
        check("t4 miss PENABLE", 32'(PENABLE), 32'h0);
        check("t4 miss ready",   32'(ready),   32'h1);
        check("t4 miss err",     32'(err),     32'h1);
        check("t4 miss rdata",   rdata,        32'h0);
        step();
        check("t4 pulse ready", 32'(ready), 32'h0);
        check("t4 pulse PSEL",  32'(PSEL),  32'h0);

        // 3. back-to-back writes; transfer stays high so the second is taken on completion
        PREADY   = 4'b0010;
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_1004; wdata = 32'h0000_00AA;
        step();
        wdata = 32'h0000_00BB;
        check("t3 setup1 PWDATA", PWDATA,    32'hAA);
        step();
        check("t3 access1 PWDATA",  PWDATA,       32'hAA);
        check("t3 access1 PENABLE", 32'(PENABLE), 32'h1);
        step();
        transfer = 1'b0;
        check("t3 done1 ready",   32'(ready),   32'h1);
        check("t3 done1 err",     32'(err),     32'h0);
        check("t3 setup2 PSEL",   32'(PSEL),    32'h2);
        check("t3 setup2 PENABLE",32'(PENABLE), 32'h0);
        check("t3 setup2 PWDATA", PWDATA,       32'hBB);
        step();
        check("t3 access2 PENABLE", 32'(PENABLE), 32'h1);
        check("t3 access2 ready",   32'(ready),   32'h0);
        step();
        check("t3 done2 ready", 32'(ready), 32'h1);
        check("t3 done2 err",   32'(err),   32'h0);
        check("t3 done2 PSEL",  32'(PSEL),  32'h0);
        step();
        check("t3 idle ready", 32'(ready), 32'h0);

        // 6. reset while waiting in ACCESS, then a normal read from slave3
        PREADY          = 4'b0000;
        PRDATA[127:96]  = 32'h0000_00CC;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010; wdata = 32'h0;
        step();
        transfer = 1'b0;
        check("t6 setup PSEL", 32'(PSEL), 32'h8);
        step();
        step();
        check("t6 wait PENABLE", 32'(PENABLE), 32'h1);
        PRESET = 1'b1;
        PREADY = 4'b1000;
        step();
        PRESET = 1'b0;
        idle_outputs("t6 rst");
        check("t6 rst err",    32'(err),    32'h0);
        check("t6 rst PADDR",  32'(PADDR),  32'h0);
        check("t6 rst PWRITE", 32'(PWRITE), 32'h0);
        step();
        idle_outputs("t6 post");
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010;
        step();
        transfer = 1'b0;
        check("t6 re PSEL",  32'(PSEL),  32'h8);
        check("t6 re PADDR", 32'(PADDR), 32'h010);
        step();
        step();
        check("t6 re ready", 32'(ready), 32'h1);
        check("t6 re err",   32'(err),   32'h0);
        check("t6 re rdata", rdata,      32'hCC);

        // 5. timeout on slave2; other slaves ready and a request during waits are ignored
        PREADY   = 4'b1011;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000;
        step();
        transfer = 1'b0;
        check("t5 setup PSEL", 32'(PSEL), 32'h4);
        step();
        check("t5 access PENABLE", 32'(PENABLE), 32'h1);
        transfer = 1'b1; addr = 32'h1000_1000;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 8) transfer = 1'b0;
            check($sformatf("t5 wait%0d ready", i), 32'(ready), 32'h0);
            check($sformatf("t5 wait%0d PSEL", i),  32'(PSEL),  32'h4);
        end
        step();
        check("t5 to ready",   32'(ready),   32'h1);
        check("t5 to err",     32'(err),     32'h1);
        check("t5 to rdata",   rdata,        32'h0);
        check("t5 to PSEL",    32'(PSEL),    32'h0);
        check("t5 to PENABLE", 32'(PENABLE), 32'h0);
        step();
        idle_outputs("t5 after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
